// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: initiator-side controller for the Gowin rPLL dynamic
// divider interface. Sequences PLL reset, waits for lock with timeout and
// retries, holds the downstream reset until lock is stable, and accepts
// runtime divider changes over a valid/ready handshake.
// Optional: define PLL_LOCK_LOSS_COUNT_EN to build the lock-loss counter.
module pll_reconfig_ctrl #(
    parameter int DEF_IDIV     = 4,
    parameter int DEF_FBDIV    = 11,
    parameter int DEF_ODIV     = 8,
    parameter int RESET_CYCLES = 32,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odiv,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       sys_reset,
    output logic       locked,
    output logic       err,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [2:0] HOLD   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] STABLE = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] FAIL   = 3'd4;

    localparam int HW = $clog2(RESET_CYCLES) + 1;
    localparam int WW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam int RW = $clog2(MAX_RETRIES) + 1;

    // Selects are driven inverted onto the PLL pins.
    localparam logic [5:0] DEF_IDSEL  = 6'(63 - DEF_IDIV);
    localparam logic [5:0] DEF_FBDSEL = 6'(63 - DEF_FBDIV);
    localparam logic [5:0] DEF_ODSEL  = 6'(63 - DEF_ODIV);

    logic [2:0]    state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [SW-1:0] stab_cnt, stab_nx;
    logic [RW-1:0] retry, retry_nx;
    logic          lock_s1, lock_s;
    logic          xfer, loss;

    assign xfer = cfg_valid && cfg_ready;

    // Two-flop synchronizer for the asynchronous PLL LOCK output
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s  <= lock_s1;
        end
    end

    // Next-state and counter update; a config transfer overrides everything
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        wait_nx  = wait_cnt;
        stab_nx  = stab_cnt;
        retry_nx = retry;
        loss     = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                    state_nx = WAIT;
                    wait_nx  = '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    stab_nx  = '0;
                end else if (wait_cnt == WW'(LOCK_TIMEOUT - 1)) begin
                    if (retry != RW'(MAX_RETRIES)) begin
                        retry_nx = retry + 1'b1;
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end else begin
                        state_nx = FAIL;
                    end
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT;
                    wait_nx  = '0;
                end else if (stab_cnt == SW'(LOCK_STABLE - 1)) begin
                    state_nx = RUN;
                end else begin
                    stab_nx = stab_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                    retry_nx = '0;
                    loss     = 1'b1;
                end
            end
            FAIL: ;
            default: begin
                state_nx = HOLD;
                hold_nx  = '0;
            end
        endcase
        if (xfer) begin
            state_nx = HOLD;
            hold_nx  = '0;
            retry_nx = '0;
            loss     = 1'b0;
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            wait_cnt   <= '0;
            stab_cnt   <= '0;
            retry      <= '0;
            pll_reset  <= 1'b1;
            sys_reset  <= 1'b1;
            locked     <= 1'b0;
            err        <= 1'b0;
            cfg_ready  <= 1'b0;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            wait_cnt  <= wait_nx;
            stab_cnt  <= stab_nx;
            retry     <= retry_nx;
            pll_reset <= (state_nx == HOLD) || (state_nx == FAIL);
            sys_reset <= (state_nx != RUN);
            locked    <= (state_nx == RUN);
            err       <= (state_nx == FAIL);
            cfg_ready <= (state_nx == RUN) || (state_nx == FAIL);
            if (xfer) begin
                pll_idsel  <= ~cfg_idiv;
                pll_fbdsel <= ~cfg_fbdiv;
                pll_odsel  <= ~cfg_odiv;
            end
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    // Saturating count of RUN-to-HOLD drops caused by lock loss
    always_ff @(posedge clk) begin
        if (reset)
            lock_loss_cnt <= 8'd0;
        else if (loss && lock_loss_cnt != 8'hff)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`else
    logic unused_loss;
    assign unused_loss   = loss;
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with short timing parameters.
module tb_pll_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idiv, cfg_fbdiv, cfg_odiv;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       sys_reset, locked, err;
    logic [7:0] lock_loss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam int EXP_LOSS = 1;
`else
    localparam int EXP_LOSS = 0;
`endif

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(50), .LOCK_STABLE(8), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odiv(cfg_odiv),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .sys_reset(sys_reset), .locked(locked), .err(err),
        .lock_loss_cnt(lock_loss_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one active edge, then settle on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // edges until sys_reset falls, capped by max
    task automatic wait_run(output int n, input int max);
        n = 0;
        while (sys_reset && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_pll_out_of_reset(output int n, input int max);
        n = 0;
        while (pll_reset && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, falls;
        logic prev;
        reset = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0;
        cfg_idiv = '0; cfg_fbdiv = '0; cfg_odiv = '0;
        @(negedge clk);
        repeat (3) tick();

        // reset state
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_loss_cnt", lock_loss_cnt, 0);
        chk("rst_idsel", pll_idsel, 59);

        // power-up: pll_reset high 4 cycles, lock 10 cycles after it falls
        reset = 1'b0;
        n = 0;
        while (pll_reset && n < 20) begin
            n++;
            tick();
        end
        chk("pwr_reset_len", n, 4);
        repeat (10) tick();
        chk("pwr_wait_sys_reset", sys_reset, 1);
        pll_lock = 1'b1;
        wait_run(n, 40);
        chk("pwr_lock_to_run", n, 11);
        chk("pwr_locked", locked, 1);
        chk("pwr_cfg_ready", cfg_ready, 1);
        chk("pwr_idsel", pll_idsel, 59);
        chk("pwr_fbdsel", pll_fbdsel, 52);
        chk("pwr_odsel", pll_odsel, 55);

        // lock loss in RUN: sys_reset back 3 cycles after the drop
        pll_lock = 1'b0;
        tick(); tick();
        chk("loss_sys_reset_2", sys_reset, 0);
        tick();
        chk("loss_sys_reset_3", sys_reset, 1);
        chk("loss_pll_reset", pll_reset, 1);
        chk("loss_cnt", lock_loss_cnt, EXP_LOSS);

        // glitch at stable count 5: back to WAIT, then 8 full cycles
        wait_pll_out_of_reset(n, 10);
        chk("glitch_hold_exit", pll_reset, 0);
        pll_lock = 1'b1;
        repeat (8) tick();
        chk("glitch_pre_sys_reset", sys_reset, 1);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_run(n, 40);
        chk("glitch_drop_to_run", n + 1, 12);
        chk("glitch_err", err, 0);

        // reconfig in RUN: transfer on the first edge
        cfg_idiv = 6'd2; cfg_fbdiv = 6'd20; cfg_odiv = 6'd4; cfg_valid = 1'b1;
        tick();
        chk("cfg_sys_reset", sys_reset, 1);
        chk("cfg_pll_reset", pll_reset, 1);
        chk("cfg_cfg_ready", cfg_ready, 0);
        chk("cfg_idsel", pll_idsel, 61);
        chk("cfg_fbdsel", pll_fbdsel, 43);
        chk("cfg_odsel", pll_odsel, 59);
        // offer while not ready must be ignored
        cfg_idiv = 6'd9; cfg_fbdiv = 6'd9; cfg_odiv = 6'd9;
        tick();
        cfg_valid = 1'b0;
        chk("ign_idsel", pll_idsel, 61);
        chk("ign_fbdsel", pll_fbdsel, 43);
        wait_run(n, 40);
        chk("cfg_relock", n, 12);
        chk("cfg_locked", locked, 1);

        // timeout and fail: 3 attempts of 4+50 cycles
        reset = 1'b1; pll_lock = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n = 0; falls = 0; prev = pll_reset;
        while (!err && n < 400) begin
            tick();
            n++;
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
        end
        chk("to_cycles", n, 162);
        chk("to_attempts", falls, 3);
        chk("to_pll_reset", pll_reset, 1);
        chk("to_cfg_ready", cfg_ready, 1);
        chk("to_sys_reset", sys_reset, 1);
        repeat (5) tick();
        chk("to_err_sticky", err, 1);

        // config from FAIL clears err and re-resets the PLL
        cfg_idiv = 6'd2; cfg_fbdiv = 6'd20; cfg_odiv = 6'd4; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("fcfg_err", err, 0);
        chk("fcfg_pll_reset", pll_reset, 1);
        chk("fcfg_idsel", pll_idsel, 61);

        // reset mid-WAIT restores defaults
        wait_pll_out_of_reset(n, 10);
        chk("mid_in_wait", pll_reset, 0);
        reset = 1'b1;
        tick();
        chk("mid_pll_reset", pll_reset, 1);
        chk("mid_idsel", pll_idsel, 59);
        chk("mid_fbdsel", pll_fbdsel, 52);
        chk("mid_odsel", pll_odsel, 55);
        chk("mid_err", err, 0);
        chk("mid_loss_cnt", lock_loss_cnt, 0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
